// File: rtl/mux_4_to_1.sv
// Four-input selector: combinational output, a registered copy of the
// selected value, and a registered strobe that fires when the select changes.
module mux_4_to_1 #(
    parameter int WIDTH = 1
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [WIDTH-1:0] i_Data0,
    input  logic [WIDTH-1:0] i_Data1,
    input  logic [WIDTH-1:0] i_Data2,
    input  logic [WIDTH-1:0] i_Data3,
    input  logic             i_Sel0,
    input  logic             i_Sel1,
    output logic [WIDTH-1:0] o_Data,
    output logic [WIDTH-1:0] o_Data_Reg,
    output logic             o_Sel_Change
);

    logic [1:0]       w_Sel;
    logic [WIDTH-1:0] w_Data;
    logic [WIDTH-1:0] r_Data_Reg;
    logic [1:0]       r_Sel_Hist;
    logic             r_Sel_Change;

    assign w_Sel = {i_Sel1, i_Sel0};

    // An unknown select falls to the default arm so the output goes X in simulation.
    always_comb begin
        w_Data = 'x;
        case (w_Sel)
            2'b00:   w_Data = i_Data0;
            2'b01:   w_Data = i_Data1;
            2'b10:   w_Data = i_Data2;
            2'b11:   w_Data = i_Data3;
            default: w_Data = 'x;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Data_Reg   <= '0;
            r_Sel_Hist   <= 2'b00;
            r_Sel_Change <= 1'b0;
        end else begin
            r_Data_Reg   <= w_Data;
            r_Sel_Hist   <= w_Sel;
            r_Sel_Change <= (w_Sel != r_Sel_Hist);
        end
    end

    assign o_Data       = w_Data;
    assign o_Data_Reg   = r_Data_Reg;
    assign o_Sel_Change = r_Sel_Change;

endmodule

// File: tb/tb_mux_4_to_1.sv
// Scoreboard bench for mux_4_to_1: directed steps push hand-computed
// expectations; a negedge monitor pops and compares them.
module tb_mux_4_to_1;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic [0:0] i_Data0 = '0, i_Data1 = '0, i_Data2 = '0, i_Data3 = '0;
    logic       i_Sel0 = 1'b0, i_Sel1 = 1'b0;
    logic [0:0] o_Data, o_Data_Reg;
    logic       o_Sel_Change;

    mux_4_to_1 #(.WIDTH(1)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst),
        .i_Data0(i_Data0), .i_Data1(i_Data1), .i_Data2(i_Data2), .i_Data3(i_Data3),
        .i_Sel0(i_Sel0), .i_Sel1(i_Sel1),
        .o_Data(o_Data), .o_Data_Reg(o_Data_Reg), .o_Sel_Change(o_Sel_Change)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        string name;
        bit    chk_reg;
        logic  e_data;
        logic  e_reg;
        logic  e_chg;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;

    // Drive one step just after a rising edge; the monitor samples at the following falling edge.
    task automatic step(input string nm, input logic rst, input logic [1:0] sel, input logic [3:0] d,
                        input bit chk_reg, input logic e_data, input logic e_reg, input logic e_chg);
        exp_t e;
        @(posedge i_Clk);
        #1;
        i_Rst   = rst;
        i_Sel1  = sel[1];
        i_Sel0  = sel[0];
        i_Data0 = d[0];
        i_Data1 = d[1];
        i_Data2 = d[2];
        i_Data3 = d[3];
        e.name = nm; e.chk_reg = chk_reg; e.e_data = e_data; e.e_reg = e_reg; e.e_chg = e_chg;
        q.push_back(e);
    endtask

    task automatic cmp(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_Clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                cmp({e.name, ".data"}, o_Data[0], e.e_data);
                if (e.chk_reg) begin
                    cmp({e.name, ".reg"}, o_Data_Reg[0], e.e_reg);
                    cmp({e.name, ".chg"}, o_Sel_Change, e.e_chg);
                end
            end
        end
    end

    initial begin : stimulus
        // Reset, then walk select with only i_Data0 set (d = {d3,d2,d1,d0}).
        step("rst0",   1, 2'd0, 4'b0001, 0, 1, 0, 0);
        step("walk0",  0, 2'd0, 4'b0001, 1, 1, 0, 0);
        step("walk1",  0, 2'd1, 4'b0001, 1, 0, 1, 0);
        step("walk2",  0, 2'd2, 4'b0001, 1, 0, 0, 1);
        step("walk3",  0, 2'd3, 4'b0001, 1, 0, 0, 1);
        // One-hot sweep, combinational output only.
        for (int k = 0; k < 4; k++)
            for (int s = 0; s < 4; s++)
                step($sformatf("oh_k%0d_s%0d", k, s), 0, 2'(s), 4'(1 << k), 0, logic'(s == k), 0, 0);
        // Registered path across a reset release with sel=2.
        step("rp_rst", 1, 2'd2, 4'b0100, 0, 1, 0, 0);
        step("rp_r1",  0, 2'd2, 4'b0100, 1, 1, 0, 0);
        step("rp_r2",  0, 2'd2, 4'b0100, 1, 1, 1, 1);
        step("rp_r3",  0, 2'd2, 4'b0100, 1, 1, 1, 0);
        // Select-change strobe: 1 -> 3 for one edge -> 0.
        step("sc0",    0, 2'd1, 4'b0000, 1, 0, 1, 0);
        step("sc1",    0, 2'd1, 4'b0000, 1, 0, 0, 1);
        step("sc2",    0, 2'd3, 4'b0000, 1, 0, 0, 0);
        step("sc3",    0, 2'd0, 4'b0000, 1, 0, 0, 1);
        step("sc4",    0, 2'd0, 4'b0000, 1, 0, 0, 1);
        step("sc5",    0, 2'd0, 4'b0000, 1, 0, 0, 0);
        step("sc6",    0, 2'd0, 4'b0000, 1, 0, 0, 0);
        // Data change under fixed sel=3.
        step("dc0",    0, 2'd3, 4'b0000, 1, 0, 0, 0);
        step("dc1",    0, 2'd3, 4'b1000, 1, 1, 0, 1);
        step("dc2",    0, 2'd3, 4'b1000, 1, 1, 1, 0);
        // Reset mid-stream with sel=3 and o_Data_Reg=1.
        step("mr0",    1, 2'd3, 4'b1000, 1, 1, 1, 0);
        step("mr1",    0, 2'd3, 4'b1000, 1, 1, 0, 0);
        step("mr2",    0, 2'd3, 4'b1000, 1, 1, 1, 1);
        step("mr3",    0, 2'd3, 4'b1000, 1, 1, 1, 0);
        // Simultaneous select and data change.
        step("sim0",   0, 2'd1, 4'b0001, 1, 0, 1, 0);
        step("sim1",   0, 2'd2, 4'b0100, 1, 1, 0, 1);
        step("sim2",   0, 2'd2, 4'b0100, 1, 1, 1, 1);
        @(posedge i_Clk);
        @(negedge i_Clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        stim_done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        if (!stim_done) begin
            $display("FAIL watchdog: time limit reached, expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
